// File: rtl/dmem_access_ctrl.sv
// Memory-stage data access sequencer: drives a req/ack bus for RV32I loads/stores,
// stalls the pipeline until completion, and returns extended load data.
module dmem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_valid,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_rdata_valid,
    output logic        o_misaligned,
    output logic        o_timeout,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t          state;
    logic [TO_W-1:0] waitCnt;
    logic [1:0]      offsetLat;
    logic [2:0]      funct3Lat;
    logic            isLoadLat;

    logic            accessS;
    logic            misalignS;
    logic [3:0]      beS;
    logic [31:0]     wdataS;

    // Pick the addressed byte/half out of the bus word and extend it to 32 bits.
    function automatic logic [31:0] extendLoad(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  extendLoad = {{24{sh[7]}}, sh[7:0]};
            3'b001:  extendLoad = {{16{sh[15]}}, sh[15:0]};
            3'b100:  extendLoad = {24'd0, sh[7:0]};
            3'b101:  extendLoad = {16'd0, sh[15:0]};
            default: extendLoad = word;
        endcase
    endfunction

    // Access decode: alignment check, byte enables and lane-replicated store data.
    always_comb begin
        accessS   = i_mem_valid & (i_mem_read | i_mem_write);
        misalignS = 1'b0;
        beS       = 4'b1111;
        wdataS    = i_wdata;
        case (i_funct3)
            3'b000, 3'b100: begin
                beS    = 4'b0001 << i_addr[1:0];
                wdataS = {4{i_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                misalignS = i_addr[0];
                beS       = 4'b0011 << {i_addr[1], 1'b0};
                wdataS    = {2{i_wdata[15:0]}};
            end
            3'b010: begin
                misalignS = (i_addr[1:0] != 2'b00);
            end
            default: begin
                misalignS = 1'b0;
            end
        endcase
    end

    // Stall and misalignment are combinational so the pipeline freezes in the request cycle.
    always_comb begin
        o_stall      = 1'b0;
        o_misaligned = 1'b0;
        case (state)
            IDLE: begin
                o_stall      = accessS & ~misalignS;
                o_misaligned = accessS & misalignS;
            end
            REQ:     o_stall = 1'b1;
            default: o_stall = 1'b0;
        endcase
    end

    // Access sequencer with registered bus and result outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            waitCnt       <= '0;
            offsetLat     <= 2'b00;
            funct3Lat     <= 3'b000;
            isLoadLat     <= 1'b0;
            o_bus_req     <= 1'b0;
            o_bus_we      <= 1'b0;
            o_bus_addr    <= 32'd0;
            o_bus_wdata   <= 32'd0;
            o_bus_be      <= 4'b0000;
            o_rdata       <= 32'd0;
            o_rdata_valid <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            o_rdata_valid <= 1'b0;
            o_timeout     <= 1'b0;
            case (state)
                IDLE: begin
                    if (accessS && !misalignS) begin
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= i_mem_write;
                        o_bus_addr  <= {i_addr[31:2], 2'b00};
                        o_bus_wdata <= wdataS;
                        o_bus_be    <= beS;
                        offsetLat   <= i_addr[1:0];
                        funct3Lat   <= i_funct3;
                        isLoadLat   <= ~i_mem_write;
                        waitCnt     <= '0;
                        state       <= REQ;
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (i_bus_ack) begin
                        o_bus_req     <= 1'b0;
                        o_rdata_valid <= isLoadLat;
                        if (isLoadLat) begin
                            o_rdata <= extendLoad(i_bus_rdata, offsetLat, funct3Lat);
                        end else begin
                            o_rdata <= o_rdata;
                        end
                        state <= DONE;
                    end else if (waitCnt == TO_W'(TIMEOUT - 1)) begin
                        o_bus_req <= 1'b0;
                        o_timeout <= 1'b1;
                        state     <= ERR;
                    end else begin
                        waitCnt <= waitCnt + TO_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed, table-driven bench for dmem_access_ctrl plus timeout and reset sequences.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        memValid, memRead, memWrite;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, rdataValid, misaligned, timeoutP;
    logic [31:0] rdata;
    logic        busReq, busWe, busAck;
    logic [31:0] busAddr, busWdata, busRdata;
    logic [3:0]  busBe;

    int passCnt = 0;
    int checkCnt = 0;

    dmem_access_ctrl #(.TIMEOUT(16), .TO_W(5)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_mem_valid(memValid), .i_mem_read(memRead), .i_mem_write(memWrite),
        .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
        .o_stall(stall), .o_rdata(rdata), .o_rdata_valid(rdataValid),
        .o_misaligned(misaligned), .o_timeout(timeoutP),
        .o_bus_req(busReq), .o_bus_we(busWe), .o_bus_addr(busAddr),
        .o_bus_wdata(busWdata), .o_bus_be(busBe),
        .i_bus_ack(busAck), .i_bus_rdata(busRdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] busRdata;
        int          ackWait;
        logic        expMis;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCnt++;
        if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        else passCnt++;
    endtask

    task automatic idleInputs();
        memValid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        funct3 = 3'b000; addr = 32'd0; wdata = 32'd0;
        busAck = 1'b0; busRdata = 32'd0;
    endtask

    task automatic doAccess(input vec_t v);
        int stallCnt;
        bit ended;
        logic [31:0] held;
        @(negedge clk);
        memValid = 1'b1; memRead = v.rd; memWrite = v.wr;
        funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        busAck = 1'b0; busRdata = v.busRdata;
        #1;
        if (v.expMis) begin
            check("mis_flag", {31'd0, misaligned}, 32'd1);
            check("mis_stall", {31'd0, stall}, 32'd0);
            @(negedge clk);
            idleInputs();
            #1;
            check("mis_no_req", {31'd0, busReq}, 32'd0);
        end else begin
            check("acc_mis_low", {31'd0, misaligned}, 32'd0);
            check("acc_stall0", {31'd0, stall}, 32'd1);
            stallCnt = 1;
            ended = 1'b0;
            for (int cyc = 1; cyc < 40; cyc++) begin
                @(negedge clk);
                busAck = (cyc == v.ackWait + 1);
                #1;
                if (cyc == 1) begin
                    check("bus_req", {31'd0, busReq}, 32'd1);
                    check("bus_we", {31'd0, busWe}, {31'd0, v.wr});
                    check("bus_addr", busAddr, {v.addr[31:2], 2'b00});
                    check("bus_be", {28'd0, busBe}, {28'd0, v.expBe});
                    if (v.wr) check("bus_wdata", busWdata, v.expWdata);
                end
                if (stall) begin
                    stallCnt++;
                end else begin
                    ended = 1'b1;
                    break;
                end
            end
            check("stall_end", {31'd0, ended}, 32'd1);
            check("stall_cycles", stallCnt, v.ackWait + 2);
            check("done_req_low", {31'd0, busReq}, 32'd0);
            check("rdata_valid", {31'd0, rdataValid}, {31'd0, ~v.wr});
            if (!v.wr) check("rdata", rdata, v.expRdata);
            held = rdata;
            idleInputs();
            @(negedge clk);
            #1;
            check("post_valid_low", {31'd0, rdataValid}, 32'd0);
            check("rdata_hold", rdata, held);
        end
    endtask

    initial begin
        int reqCnt;
        vec_t v;
        //          rd    wr    f3      addr          wdata          busRdata     wait mis  be       expWdata       expRdata
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEADBEEF, 0, 1'b0, 4'b1111, 32'h0,         32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0,         32'h80112233, 0, 1'b0, 4'b1000, 32'h0,         32'hFFFFFF80};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0,         32'h80112233, 0, 1'b0, 4'b1000, 32'h0,         32'h00000080};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0302, 32'h0000ABCD,  32'h0,        3, 1'b0, 4'b1100, 32'hABCDABCD,  32'h0};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0,         32'h80112233, 1, 1'b0, 4'b1100, 32'h0,         32'hFFFF8011};
        vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0200, 32'h0,         32'h80112233, 0, 1'b0, 4'b0011, 32'h0,         32'h00002233};
        vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h123456A5,  32'h0,        1, 1'b0, 4'b0010, 32'hA5A5A5A5,  32'h0};
        vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_040C, 32'hCAFEF00D,  32'h0,        0, 1'b0, 4'b1111, 32'hCAFEF00D,  32'h0};
        vecs[8]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0201, 32'h0,         32'h80112233, 2, 1'b0, 4'b0010, 32'h0,         32'h00000022};
        vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,         32'h0,        0, 1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[10] = '{1'b1, 1'b0, 3'b001, 32'h0000_0203, 32'h0,         32'h0,        0, 1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[11] = '{1'b0, 1'b1, 3'b101, 32'h0000_0201, 32'h0,         32'h0,        0, 1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[12] = '{1'b1, 1'b1, 3'b010, 32'h0000_0500, 32'h11223344,  32'hFFFFFFFF, 0, 1'b0, 4'b1111, 32'h11223344,  32'h0};
        vecs[13] = '{1'b1, 1'b0, 3'b100, 32'h0000_0302, 32'h0,         32'h00FE0000, 0, 1'b0, 4'b0100, 32'h0,         32'h000000FE};

        idleInputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_req", {31'd0, busReq}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_be", {28'd0, busBe}, 32'd0);
        check("rst_timeout", {31'd0, timeoutP}, 32'd0);

        foreach (vecs[i]) doAccess(vecs[i]);

        // Store with no ack: 16 request cycles, one ERR cycle, late ack ignored.
        @(negedge clk);
        memValid = 1'b1; memWrite = 1'b1; funct3 = 3'b010; addr = 32'h600; wdata = 32'h5A5A5A5A;
        reqCnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            #1;
            if (!busReq) break;
            reqCnt++;
        end
        check("to_req_cycles", reqCnt, 32'd16);
        check("to_flag", {31'd0, timeoutP}, 32'd1);
        check("to_stall", {31'd0, stall}, 32'd0);
        check("to_rvalid", {31'd0, rdataValid}, 32'd0);
        idleInputs();
        @(negedge clk);
        #1;
        check("to_pulse_end", {31'd0, timeoutP}, 32'd0);
        busAck = 1'b1; busRdata = 32'h12345678;
        @(negedge clk);
        busAck = 1'b0;
        #1;
        check("late_ack_req", {31'd0, busReq}, 32'd0);
        check("late_ack_rvalid", {31'd0, rdataValid}, 32'd0);
        check("late_ack_stall", {31'd0, stall}, 32'd0);

        // Reset in the second REQ cycle, then a normal load.
        @(negedge clk);
        memValid = 1'b1; memRead = 1'b1; funct3 = 3'b010; addr = 32'h700;
        @(negedge clk);
        #1;
        check("rr_req1", {31'd0, busReq}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        idleInputs();
        @(negedge clk);
        rst = 1'b0;
        busAck = 1'b1; busRdata = 32'hFFFF0000;
        #1;
        check("rr_req", {31'd0, busReq}, 32'd0);
        check("rr_addr", busAddr, 32'd0);
        check("rr_rdata", rdata, 32'd0);
        check("rr_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        busAck = 1'b0;
        #1;
        check("rr_ack_ignored", {31'd0, rdataValid}, 32'd0);
        v = vecs[0];
        v.busRdata = 32'h0BADF00D; v.expRdata = 32'h0BADF00D; v.addr = 32'h700;
        doAccess(v);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences data-memory accesses for the Memory stage of the pipelined RV32I core. It takes the load/store presented by the EX/MEM pipeline register and drives a req/ack data bus. It stalls the pipeline until the access completes, and returns aligned, sign- or zero-extended load data. It also flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 16, max cycles REQ may wait for i_bus_ack before abort (must be >= 1)
TO_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous, active-high reset
i_mem_valid  in  1  M stage holds a valid instruction
i_mem_read  in  1  M-stage instruction is a load
i_mem_write  in  1  M-stage instruction is a store (MemWriteM)
i_funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_addr  in  32  byte address (ALUResultM)
i_wdata  in  32  store data (WriteDataM)
o_stall  out  1  hold F/D/E stages and EX/MEM register
o_rdata  out  32  extended load data for writeback
o_rdata_valid  out  1  o_rdata valid this cycle
o_misaligned  out  1  pulse: access rejected, misaligned
o_timeout  out  1  pulse: access aborted, no ack
o_bus_req  out  1  bus request, held until ack or abort
o_bus_we  out  1  1 = write
o_bus_addr  out  32  word address; [1:0] forced to 0
o_bus_wdata  out  32  lane-replicated store data
o_bus_be  out  4  byte enables
i_bus_ack  in  1  bus completes access this cycle
i_bus_rdata  in  32  read word, valid with i_bus_ack

Behaviour:
- Reset (synchronous): state IDLE, counter 0. All registered outputs are 0: o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be, o_rdata, o_rdata_valid, o_timeout.
- Reset mid-access: o_bus_req drops at the reset edge. Any later ack is ignored.
- access = i_mem_valid & (i_mem_read | i_mem_write). If both read and write are set, the access is a write and the read is ignored.
- Misaligned condition: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- Misaligned access in IDLE: o_misaligned=1 combinationally and o_stall=0. No bus activity and the FSM stays in IDLE. o_misaligned is a pulse per cycle the condition is presented.
- States: IDLE, REQ, DONE, ERR.
- IDLE:
  - Aligned access: o_stall=1 combinationally. At the edge, register the bus outputs and go to REQ with counter=0.
  - Byte enables: B/BU -> 0001<<addr[1:0]; H/HU -> 0011<<{addr[1],1'b0}; W -> 1111.
  - Store data is replicated: byte -> {4{wdata[7:0]}}, half -> {2{wdata[15:0]}}, word -> wdata. For loads, wdata is don't-care and be is still driven.
- REQ:
  - o_stall=1 and o_bus_req=1; all bus fields stay stable.
  - On i_bus_ack: drop req. For a load, capture i_bus_rdata extracted by the latched offset/funct3. B/H sign-extend, BU/HU zero-extend, W passes through. Go to DONE.
  - Without ack, the counter increments. When the counter reaches TIMEOUT-1 without ack: drop req and go to ERR.
- DONE: lasts one cycle. o_stall=0. o_rdata_valid=1 for loads, 0 for stores. The EX/MEM register advances at this edge. Next state is IDLE unconditionally, and a following access is accepted there.
- ERR: lasts one cycle. o_stall=0, o_timeout=1, o_rdata_valid=0. Next state is IDLE.
- Minimum latency (ack in the first REQ cycle): request seen in cycle 0, DONE in cycle 2. This gives 2 stall cycles. Each extra ack wait adds one stall cycle.
- o_rdata holds its last value outside DONE. Consumers must qualify it with o_rdata_valid.
- i_bus_ack outside REQ is ignored.
- Inputs may change during REQ: latched values are used and the pipeline is held.

Test Plan:
- LW addr 0x100, ack in first REQ cycle, rdata 0xDEADBEEF -> be=1111, bus_addr 0x100, stall high 2 cycles, DONE o_rdata=0xDEADBEEF with valid=1.
- LB addr 0x203, rdata 0x80112233 -> be=1000, o_rdata=0xFFFFFF80. Same access as LBU -> o_rdata=0x00000080.
- SH addr 0x302, wdata 0x0000ABCD, ack after 3 wait cycles -> we=1, be=1100, bus_wdata=0xABCDABCD, stall 5 cycles, rdata_valid=0.
- LW addr 0x101 -> o_misaligned=1, o_stall=0, o_bus_req never asserted.
- Store with no ack, TIMEOUT=16 -> req high 16 cycles, then ERR with o_timeout=1 and o_stall=0 for 1 cycle, then IDLE. A late ack is ignored.
- i_rst asserted in the 2nd REQ cycle -> req=0 next cycle, state IDLE, all outputs 0. A subsequent LW completes normally.
